variant_table_inverse_search: RTL and testbench
===============================================

// Module: variant_table_inverse_search
//
// PURPOSE
// - Inverse of the 4-bit variant map.
// - Given a TARGET output value, the block sequentially scans NOM = 0..F through the forward map.
// - It reports every NOM whose mapped value equals TARGET, one at a time, over a valid/ack handshake.
// - It ends with a DONE pulse and the total number of preimages.
// - The map is not a bijection (C, 1 and A each have two preimages; 4, 5 and B have none), so a scan is required.
//
// PARAMETERS
// - COUNT_W  5  width of HIT_COUNT; must hold 0..16.
//
// PORTS
// - CLK        in   1        single clock, all logic on rising edge
// - RST        in   1        synchronous, active-high reset
// - START      in   1        begin a search; sampled only when BUSY=0 and DONE=0
// - TARGET     in   4        value to invert; latched on accepted START
// - HIT_ACK    in   1        consumer accepts current hit; meaningful only while HIT_VALID=1
// - BUSY       out  1        search in progress (states SCAN, HOLD)
// - HIT_VALID  out  1        HIT_NOM holds a preimage of latched TARGET
// - HIT_NOM    out  4        preimage index; stable while HIT_VALID=1
// - DONE       out  1        one-cycle pulse; search finished
// - HIT_COUNT  out  COUNT_W  number of acked hits; final when DONE=1
//
// BEHAVIOUR
// - Forward map (NOM->Y): 0->C 1->2 2->9 3->A 4->7 5->1 6->C 7->0 8->F 9->1 A->3 B->D C->8 D->E E->A F->6.
// - Reset: state=IDLE; BUSY, HIT_VALID, DONE=0; HIT_NOM=0; HIT_COUNT=0; latched target=0; idx=0.
//   - RST wins over every other input in any state, including mid-SCAN/HOLD; no DONE is emitted for an aborted search.
// - FSM states: IDLE, SCAN, HOLD, FIN (registered, all outputs registered).
// - IDLE: START=1 -> latch TARGET, idx<=0, HIT_COUNT<=0, goto SCAN. Otherwise hold; HIT_COUNT keeps its last value.
// - SCAN: map(idx) is compared combinationally with the latched target each cycle.
//   - match -> HIT_NOM<=idx, HIT_VALID<=1, goto HOLD
//   - no match, idx!=F -> idx<=idx+1
//   - no match, idx==F -> goto FIN
// - HOLD: HIT_VALID=1 with HIT_NOM held stable until HIT_ACK=1 is sampled. On ack:
//   - HIT_VALID<=0 and HIT_COUNT<=HIT_COUNT+1
//   - idx==F -> goto FIN
//   - else idx<=idx+1, goto SCAN
//   - HIT_ACK is ignored in every state other than HOLD.
// - FIN: DONE=1 for exactly one cycle, BUSY=0, then goto IDLE. START during FIN is ignored.
// - START while BUSY=1 is ignored; the TARGET change has no effect on the running search.
// - Timing: each NOM costs 1 cycle in SCAN; each hit costs 1 extra cycle in HOLD plus the ack wait.
//   - A zero-hit search has DONE high 17 cycles after the START edge.
//   - A hit at idx k with immediate ack has HIT_VALID high in cycle k+2 after the START edge.
// - HIT_COUNT is never incremented beyond 16. Width rule: idx is 4 bits; the idx==F check precedes any increment, so there is no wrap.
//
// STRUCTURE
// - Shared include variant_pkg.vh holds:
//   - forward map as a constant function var_map(nom) returning 4 bits
//   - FSM state localparams (IDLE=0, SCAN=1, HOLD=2, FIN=3)
//   - width constants (NOM_W=4, COUNT_W default)
// - One sub-module: variant_fwd_map (combinational, 4-in/4-out, wraps var_map). Instantiated once, driven by idx.
// - Top holds the FSM, idx counter, target latch and output registers.
//
// TESTING
// - Reset: RST=1 for 2 cycles -> BUSY, HIT_VALID, DONE, HIT_NOM, HIT_COUNT all 0; START held with RST=1 is ignored.
// - TARGET=C, HIT_ACK tied 1:
//   - HIT_NOM=0, then HIT_NOM=6, each HIT_VALID for 1 cycle
//   - DONE once, HIT_COUNT=2
// - TARGET=4 -> HIT_VALID never asserts; DONE exactly 17 cycles after START; HIT_COUNT=0.
// - TARGET=6, ack delayed 5 cycles:
//   - HIT_NOM=F and HIT_VALID held stable for all 5 wait cycles
//   - DONE on the cycle after the ack; HIT_COUNT=1
// - TARGET=A; mid-search START with TARGET=5 -> ignored, hits 3 and E reported. Then:
//   - new search TARGET=1, RST asserted in HOLD (HIT_NOM=5) -> IDLE, no DONE
//   - next START TARGET=1 -> hits 5, 9
// - Sweep TARGET 0..F with random ack delays 0..3:
//   - hit list matches the reference model for every target
//   - sum of HIT_COUNT over all targets = 16

Source files
------------

// File: rtl/variant_table_inverse_search_pkg.sv
// Shared definitions for the inverse variant-map search: forward map, FSM states, widths.
package variant_table_inverse_search_pkg;

  localparam int NOM_W       = 4;
  localparam int COUNT_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2,
    FIN  = 2'd3
  } state_t;

  // Forward map NOM -> Y; not a bijection, hence the scan in the top.
  function automatic logic [NOM_W-1:0] var_map(input logic [NOM_W-1:0] nom);
    logic [NOM_W-1:0] y;
    case (nom)
      4'h0: y = 4'hC;
      4'h1: y = 4'h2;
      4'h2: y = 4'h9;
      4'h3: y = 4'hA;
      4'h4: y = 4'h7;
      4'h5: y = 4'h1;
      4'h6: y = 4'hC;
      4'h7: y = 4'h0;
      4'h8: y = 4'hF;
      4'h9: y = 4'h1;
      4'hA: y = 4'h3;
      4'hB: y = 4'hD;
      4'hC: y = 4'h8;
      4'hD: y = 4'hE;
      4'hE: y = 4'hA;
      4'hF: y = 4'h6;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/variant_table_inverse_search_fwd_map.sv
// Combinational wrapper around the forward variant map.
module variant_fwd_map
  import variant_table_inverse_search_pkg::*;
(
  input  logic [NOM_W-1:0] nom,
  output logic [NOM_W-1:0] y
);

  assign y = var_map(nom);

endmodule

// File: rtl/variant_table_inverse_search.sv
// Scans NOM 0..F through the forward map and streams every preimage of TARGET
// over a valid/ack handshake, finishing with a DONE pulse and the hit count.
module variant_table_inverse_search
  import variant_table_inverse_search_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [NOM_W-1:0]   TARGET,
  input  logic               HIT_ACK,
  output logic               BUSY,
  output logic               HIT_VALID,
  output logic [NOM_W-1:0]   HIT_NOM,
  output logic               DONE,
  output logic [COUNT_W-1:0] HIT_COUNT
);

  localparam logic [NOM_W-1:0]   IDX_LAST  = '1;
  localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(16);

  state_t             state, state_nx;
  logic [NOM_W-1:0]   idx, idx_nx;
  logic [NOM_W-1:0]   tgt, tgt_nx;
  logic [NOM_W-1:0]   nom_nx;
  logic [NOM_W-1:0]   map_y;
  logic [COUNT_W-1:0] cnt_nx;
  logic               hv_nx, done_nx, busy_nx, match;

  variant_fwd_map u_map (
    .nom (idx),
    .y   (map_y)
  );

  assign match = (map_y == tgt);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      idx       <= '0;
      tgt       <= '0;
      HIT_NOM   <= '0;
      HIT_VALID <= 1'b0;
      DONE      <= 1'b0;
      BUSY      <= 1'b0;
      HIT_COUNT <= '0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      tgt       <= tgt_nx;
      HIT_NOM   <= nom_nx;
      HIT_VALID <= hv_nx;
      DONE      <= done_nx;
      BUSY      <= busy_nx;
      HIT_COUNT <= cnt_nx;
    end
  end

  // DONE is raised on the transition into FIN so it is high exactly while in FIN.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    tgt_nx   = tgt;
    nom_nx   = HIT_NOM;
    hv_nx    = HIT_VALID;
    cnt_nx   = HIT_COUNT;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (START && !DONE) begin
          tgt_nx   = TARGET;
          idx_nx   = '0;
          cnt_nx   = '0;
          state_nx = SCAN;
        end
      end
      SCAN: begin
        if (match) begin
          nom_nx   = idx;
          hv_nx    = 1'b1;
          state_nx = HOLD;
        end else if (idx == IDX_LAST) begin
          done_nx  = 1'b1;
          state_nx = FIN;
        end else begin
          idx_nx = idx + 1'b1;
        end
      end
      HOLD: begin
        if (HIT_ACK) begin
          hv_nx = 1'b0;
          if (HIT_COUNT != COUNT_MAX) cnt_nx = HIT_COUNT + 1'b1;
          if (idx == IDX_LAST) begin
            done_nx  = 1'b1;
            state_nx = FIN;
          end else begin
            idx_nx   = idx + 1'b1;
            state_nx = SCAN;
          end
        end
      end
      FIN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx == SCAN) || (state_nx == HOLD);
  end

endmodule

// File: tb/tb_variant_table_inverse_search.sv
// Randomized self-checking bench; expected timeline derived from the map and ack delays.
module tb_variant_table_inverse_search;

  logic       CLK = 1'b0;
  logic       RST, START, HIT_ACK;
  logic [3:0] TARGET;
  logic       BUSY, HIT_VALID, DONE;
  logic [3:0] HIT_NOM;
  logic [4:0] HIT_COUNT;

  int errs = 0;
  int checks = 0;
  int fmap[16] = '{12, 2, 9, 10, 7, 1, 12, 0, 15, 1, 3, 13, 8, 14, 10, 6};
  int obs_q[$];
  int done_seen;
  int sum_cnt;

  variant_table_inverse_search #(.COUNT_W(5)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .TARGET    (TARGET),
    .HIT_ACK   (HIT_ACK),
    .BUSY      (BUSY),
    .HIT_VALID (HIT_VALID),
    .HIT_NOM   (HIT_NOM),
    .DONE      (DONE),
    .HIT_COUNT (HIT_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle c counts rising edges since START was driven (c=1 right after the sampling edge).
  // ack_mode: 0 = ack low outside hold, 1 = random noise, 2 = tied high.
  task automatic run_search(input int tgt, input int fixw, input int maxw, input int ack_mode,
                            input int restart_c, input int rst_c);
    int hk[$];
    int hs[$];
    int hw[$];
    int acc, done_c, w, exp_cnt, exp_nom;
    bit exp_v, exp_ack, prev_hv;
    obs_q.delete();
    done_seen = -1;
    prev_hv = 1'b0;
    for (int n = 0; n < 16; n++) if (fmap[n] == tgt) hk.push_back(n);
    acc = 0;
    foreach (hk[j]) begin
      w = (fixw >= 0) ? fixw : int'($urandom_range(maxw, 0));
      hw.push_back(w);
      hs.push_back(hk[j] + 2 + acc);
      acc += w + 1;
    end
    done_c = 17 + acc;
    @(negedge CLK);
    START = 1'b1;
    TARGET = 4'(tgt);
    HIT_ACK = (ack_mode == 2);
    for (int c = 1; c <= done_c + 1; c++) begin
      @(negedge CLK);
      START = 1'b0;
      TARGET = 4'($urandom);
      if (rst_c > 0 && c > rst_c) begin
        RST = 1'b0;
        HIT_ACK = 1'b0;
        if (c == rst_c + 1) begin
          chk("abort_hit_valid", HIT_VALID, 0);
          chk("abort_hit_nom", HIT_NOM, 0);
          chk("abort_hit_count", HIT_COUNT, 0);
        end
        chk("abort_busy", BUSY, 0);
        chk("abort_done", DONE, 0);
        if (c == rst_c + 5) break;
        continue;
      end
      exp_v = 1'b0; exp_nom = 0; exp_cnt = 0; exp_ack = 1'b0;
      foreach (hs[j]) begin
        if (c >= hs[j] && c <= hs[j] + hw[j]) begin
          exp_v = 1'b1;
          exp_nom = hk[j];
          if (c == hs[j] + hw[j]) exp_ack = 1'b1;
        end
        if (c >= hs[j] + hw[j] + 1) exp_cnt++;
      end
      if (HIT_VALID && !prev_hv) obs_q.push_back(int'(HIT_NOM));
      prev_hv = HIT_VALID;
      if (DONE) done_seen = c;
      chk("hit_valid", HIT_VALID, exp_v);
      if (exp_v) chk("hit_nom", HIT_NOM, exp_nom);
      chk("busy", BUSY, c < done_c);
      chk("done", DONE, c == done_c);
      chk("hit_count", HIT_COUNT, exp_cnt);
      if (exp_v) HIT_ACK = exp_ack;
      else if (ack_mode == 2) HIT_ACK = 1'b1;
      else if (ack_mode == 1) HIT_ACK = 1'($urandom);
      else HIT_ACK = 1'b0;
      if (c == restart_c || c == done_c) begin
        START = 1'b1;
        TARGET = 4'h5;
      end
      if (rst_c > 0 && c == rst_c) RST = 1'b1;
    end
    START = 1'b0;
    HIT_ACK = 1'b0;
  endtask

  initial begin
    RST = 1'b1; START = 1'b1; TARGET = 4'hC; HIT_ACK = 1'b0;
    for (int i = 0; i < 2; i++) @(negedge CLK);
    chk("rst_busy", BUSY, 0);
    chk("rst_hit_valid", HIT_VALID, 0);
    chk("rst_done", DONE, 0);
    chk("rst_hit_nom", HIT_NOM, 0);
    chk("rst_hit_count", HIT_COUNT, 0);
    RST = 1'b0; START = 1'b0;
    @(negedge CLK);
    chk("idle_busy", BUSY, 0);

    run_search(12, 0, 0, 2, 0, 0);
    chk("c_nhits", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      chk("c_hit0", obs_q[0], 0);
      chk("c_hit1", obs_q[1], 6);
    end
    chk("c_done_cycle", done_seen, 19);
    chk("c_count", HIT_COUNT, 2);

    run_search(4, 0, 0, 1, 0, 0);
    chk("t4_nhits", obs_q.size(), 0);
    chk("t4_done_cycle", done_seen, 17);
    chk("t4_count", HIT_COUNT, 0);

    run_search(6, 5, 0, 0, 0, 0);
    chk("t6_nhits", obs_q.size(), 1);
    if (obs_q.size() == 1) chk("t6_hit0", obs_q[0], 15);
    chk("t6_done_cycle", done_seen, 23);
    chk("t6_count", HIT_COUNT, 1);

    run_search(10, -1, 3, 1, 3, 0);
    chk("ta_nhits", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      chk("ta_hit0", obs_q[0], 3);
      chk("ta_hit1", obs_q[1], 14);
    end
    chk("ta_count", HIT_COUNT, 2);

    run_search(1, 3, 0, 0, 0, 8);
    chk("abort_seen_hit", obs_q.size() >= 1 ? obs_q[0] : -1, 5);
    chk("abort_no_done", done_seen, -1);

    run_search(1, -1, 3, 1, 0, 0);
    chk("t1_nhits", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      chk("t1_hit0", obs_q[0], 5);
      chk("t1_hit1", obs_q[1], 9);
    end

    sum_cnt = 0;
    for (int t = 0; t < 16; t++) begin
      run_search(t, -1, 3, 1, 0, 0);
      sum_cnt += int'(HIT_COUNT);
    end
    chk("sweep_sum", sum_cnt, 16);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
